// File: rtl/partition_buffer_if.sv
// Stream bundle between the partitioning gate, the tuple buffer and the partition writer.
// The buffer uses the slave view; the upstream/downstream side uses master.
interface partition_buffer_if #(
    parameter int INPUT_SIZE = 64
);
    logic                  in_ready;
    logic [INPUT_SIZE-1:0] in_data;
    logic [31:0]           in_tag;
    logic                  in_valid;
    logic [63:0]           in_serialnum;
    logic                  in_was_joined;
    logic                  in_last_processed;
    logic                  out_ready;
    logic [INPUT_SIZE-1:0] out_data;
    logic [31:0]           out_tag;
    logic [63:0]           out_serialnum;
    logic                  out_was_joined;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_done;
    logic [31:0]           tuple_count;
    logic                  tag_error;

    modport slave (
        output in_ready,
        input  in_data, in_tag, in_valid, in_serialnum, in_was_joined, in_last_processed,
        input  out_ready,
        output out_data, out_tag, out_serialnum, out_was_joined, out_valid, out_last, out_done,
        output tuple_count, tag_error
    );

    modport master (
        input  in_ready,
        output in_data, in_tag, in_valid, in_serialnum, in_was_joined, in_last_processed,
        output out_ready,
        input  out_data, out_tag, out_serialnum, out_was_joined, out_valid, out_last, out_done,
        input  tuple_count, tag_error
    );
endinterface

// File: rtl/partition_buffer.sv
// Elastic FWFT tuple buffer after the partitioning gate; drains and flags done at end-of-stream.
// Optional macro PARTITION_BUFFER_TAG_CHECK_EN enables the sticky mis-routed-tag flag.
module partition_buffer #(
    parameter int INPUT_SIZE   = 64,
    parameter int DEPTH        = 16,
    parameter int ID           = 0,
    parameter int DECISION_BIT = 0
) (
    input logic               clk,
    input logic               reset,
    partition_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef struct packed {
        logic [INPUT_SIZE-1:0] data;
        logic [31:0]           tag;
        logic [63:0]           serialnum;
        logic                  was_joined;
    } entry_t;

    typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;

    generate
        if (DEPTH < 2 || (1 << AW) != DEPTH || DECISION_BIT < 0 || DECISION_BIT > 31 || ID < 0)
        begin : g_bad_cfg
            $error("partition_buffer: illegal parameter set");
        end
    endgenerate

    state_t        state, state_nxt;
    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   tuple_count;
    logic          full, empty, push, pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // A same-cycle pop never opens a slot for the push: in_ready looks only at current occupancy.
    assign bus.in_ready = (state == FILL) && !full;
    assign push  = bus.in_valid && bus.in_ready;
    assign pop   = !empty && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= '{data: bus.in_data, tag: bus.in_tag,
                             serialnum: bus.in_serialnum, was_joined: bus.in_was_joined};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tuple_count <= '0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                tuple_count <= tuple_count + 32'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FILL;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:  if (bus.in_last_processed && !bus.in_valid) state_nxt = DRAIN;
            // Leave DRAIN either already empty or on the pop of the last entry.
            DRAIN: if (empty || (pop && count == {{AW{1'b0}}, 1'b1})) state_nxt = DONE;
            DONE:  state_nxt = DONE;
            default: state_nxt = FILL;
        endcase
    end

    assign head               = mem[rd_ptr];
    assign bus.out_data       = head.data;
    assign bus.out_tag        = head.tag;
    assign bus.out_serialnum  = head.serialnum;
    assign bus.out_was_joined = head.was_joined;
    assign bus.out_valid      = !empty;
    assign bus.out_last       = (state == DRAIN) && (count == {{AW{1'b0}}, 1'b1});
    assign bus.out_done       = (state == DONE);
    assign bus.tuple_count    = tuple_count;

`ifdef PARTITION_BUFFER_TAG_CHECK_EN
    localparam logic ID_BIT = 1'(ID % 2);
    logic tag_error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                           tag_error <= 1'b0;
        else if (push && bus.in_tag[DECISION_BIT] != ID_BIT) tag_error <= 1'b1;
    end

    assign bus.tag_error = tag_error;
`else
    assign bus.tag_error = 1'b0;
`endif
endmodule

// File: tb/tb_partition_buffer.sv
// Self-checking bench for partition_buffer: directed table, corner sequences, random vs queue model.
module tb_partition_buffer;
    localparam int W = 64;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    partition_buffer_if #(.INPUT_SIZE(W)) bus ();

    partition_buffer #(.INPUT_SIZE(W), .DEPTH(DEPTH), .ID(1), .DECISION_BIT(0)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic        vld;
        logic [63:0] ser;
        logic        ordy;
        logic        exp_vld;
        logic [63:0] exp_ser;
        logic [31:0] exp_cnt;
    } vec_t;

    function automatic logic [63:0] mk_data(input logic [63:0] s);
        return s ^ 64'hA5A5_0000_1234_0000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tags keep bit 0 set so they match ID=1 unless a test overrides them.
    task automatic drive(input logic v, input logic [63:0] s);
        bus.in_valid      = v;
        bus.in_serialnum  = s;
        bus.in_data       = mk_data(s);
        bus.in_tag        = 32'(s << 1) | 32'h1;
        bus.in_was_joined = s[0];
    endtask

    task automatic do_reset();
        drive(1'b0, 64'd0);
        bus.in_last_processed = 1'b0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_head(input string nm, input logic [63:0] s);
        chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({nm, "_serial"}, bus.out_serialnum, s);
        chk({nm, "_data"}, bus.out_data, mk_data(s));
    endtask

    vec_t vecs[7];
    logic [63:0] mq[$];
    int phase;
    logic [63:0] nser;
    logic pv, po, dpush, dpop;
    int guard;

    initial begin
        drive(1'b0, 64'd0);
        bus.in_last_processed = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_out_done", 64'(bus.out_done), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_out_serial", bus.out_serialnum, 64'd0);
        chk("rst_out_joined", 64'(bus.out_was_joined), 64'd0);
        chk("rst_tuple_count", 64'(bus.tuple_count), 64'd0);
        chk("rst_tag_error", 64'(bus.tag_error), 64'd0);

        // table: push 1,2,3 held, then release
        vecs[0] = '{1'b1, 64'd1, 1'b0, 1'b1, 64'd1, 32'd1};
        vecs[1] = '{1'b1, 64'd2, 1'b0, 1'b1, 64'd1, 32'd2};
        vecs[2] = '{1'b1, 64'd3, 1'b0, 1'b1, 64'd1, 32'd3};
        vecs[3] = '{1'b0, 64'd0, 1'b0, 1'b1, 64'd1, 32'd3};
        vecs[4] = '{1'b0, 64'd0, 1'b1, 1'b1, 64'd2, 32'd3};
        vecs[5] = '{1'b0, 64'd0, 1'b1, 1'b1, 64'd3, 32'd3};
        vecs[6] = '{1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 32'd3};
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].vld, vecs[i].ser);
            bus.out_ready = vecs[i].ordy;
            tick();
            chk($sformatf("tbl%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_vld));
            chk($sformatf("tbl%0d_count", i), 64'(bus.tuple_count), 64'(vecs[i].exp_cnt));
            if (vecs[i].exp_vld) begin
                chk($sformatf("tbl%0d_serial", i), bus.out_serialnum, vecs[i].exp_ser);
                chk($sformatf("tbl%0d_data", i), bus.out_data, mk_data(vecs[i].exp_ser));
                chk($sformatf("tbl%0d_joined", i), 64'(bus.out_was_joined), 64'(vecs[i].exp_ser[0]));
            end
        end

        // full FIFO: push+pop while full must refuse the push
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_in_ready", 64'(bus.in_ready), 64'd1);
            drive(1'b1, 64'(100 + i));
            tick();
        end
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        drive(1'b1, 64'd200);
        bus.out_ready = 1'b1;
        chk("full_pop_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("after_pp_in_ready", 64'(bus.in_ready), 64'd1);
        chk("after_pp_count", 64'(bus.tuple_count), 64'd16);
        drive(1'b0, 64'd0);
        for (int i = 1; i < DEPTH; i++) begin
            check_head("full_drain", 64'(100 + i));
            tick();
        end
        chk("full_drained_valid", 64'(bus.out_valid), 64'd0);

        // end-of-stream with 2 entries; in_valid during DRAIN is ignored
        do_reset();
        drive(1'b1, 64'd1); tick();
        drive(1'b1, 64'd2); tick();
        drive(1'b0, 64'd0);
        bus.in_last_processed = 1'b1;
        tick();
        chk("drain_in_ready", 64'(bus.in_ready), 64'd0);
        chk("drain_last_early", 64'(bus.out_last), 64'd0);
        drive(1'b1, 64'd99);
        tick();
        chk("drain_ignore_push", 64'(bus.tuple_count), 64'd2);
        drive(1'b0, 64'd0);
        bus.out_ready = 1'b1;
        check_head("drain_h1", 64'd1);
        chk("drain_last_h1", 64'(bus.out_last), 64'd0);
        tick();
        check_head("drain_h2", 64'd2);
        chk("drain_last_h2", 64'(bus.out_last), 64'd1);
        chk("drain_done_pre", 64'(bus.out_done), 64'd0);
        tick();
        chk("drain_done", 64'(bus.out_done), 64'd1);
        chk("drain_empty", 64'(bus.out_valid), 64'd0);
        chk("drain_last_off", 64'(bus.out_last), 64'd0);
        tick(); tick();
        chk("drain_done_sticky", 64'(bus.out_done), 64'd1);

        // end-of-stream with empty FIFO
        do_reset();
        bus.in_last_processed = 1'b1;
        tick();
        chk("eos_empty_last1", 64'(bus.out_last), 64'd0);
        chk("eos_empty_done1", 64'(bus.out_done), 64'd0);
        tick();
        chk("eos_empty_last2", 64'(bus.out_last), 64'd0);
        chk("eos_empty_done2", 64'(bus.out_done), 64'd1);

        // asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'(10 + i));
            tick();
        end
        drive(1'b0, 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_valid", 64'(bus.out_valid), 64'd0);
        chk("async_count", 64'(bus.tuple_count), 64'd0);
        chk("async_serial", bus.out_serialnum, 64'd0);
        chk("async_in_ready", 64'(bus.in_ready), 64'd1);
        #1 reset = 1'b0;
        drive(1'b1, 64'd7);
        tick();
        drive(1'b0, 64'd0);
        check_head("async_next", 64'd7);
        chk("async_next_count", 64'(bus.tuple_count), 64'd1);

        // random traffic against a queue model, then end-of-stream drain
        do_reset();
        mq = {};
        phase = 0;
        nser = 64'd1000;
        for (int c = 0; c < 600; c++) begin
            pv = ($urandom_range(0, 9) < 7);
            po = ($urandom_range(0, 9) < 5);
            drive(pv, nser);
            bus.out_ready = po;
            chk("rnd_in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
            chk("rnd_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
            if (mq.size() > 0) chk("rnd_head", bus.out_serialnum, mq[0]);
            dpush = pv && (mq.size() < DEPTH);
            dpop  = po && (mq.size() > 0);
            tick();
            if (dpop) void'(mq.pop_front());
            if (dpush) begin
                mq.push_back(nser);
                nser++;
            end
            chk("rnd_count", 64'(bus.tuple_count), nser - 64'd1000);
        end
        drive(1'b0, 64'd0);
        bus.in_last_processed = 1'b1;
        guard = 0;
        while (phase != 2 && guard < 200) begin
            po = $urandom_range(0, 1) == 1;
            bus.out_ready = po;
            chk("eos_last", 64'(bus.out_last), 64'(phase == 1 && mq.size() == 1));
            if (mq.size() > 0) chk("eos_head", bus.out_serialnum, mq[0]);
            dpop = po && (mq.size() > 0);
            tick();
            if (phase == 0) phase = 1;
            else if (phase == 1 && (mq.size() == 0 || (dpop && mq.size() == 1))) phase = 2;
            if (dpop) void'(mq.pop_front());
            chk("eos_done", 64'(bus.out_done), 64'(phase == 2));
            guard++;
        end
        chk("eos_terminated", 64'(phase == 2), 64'd1);
        chk("rnd_tag_error", 64'(bus.tag_error), 64'd0);

        // mis-routed tag: bit 0 clear while ID=1
        do_reset();
        drive(1'b1, 64'd5);
        bus.in_tag = 32'h0000_0002;
        tick();
        drive(1'b0, 64'd0);
`ifdef PARTITION_BUFFER_TAG_CHECK_EN
        chk("tag_error_set", 64'(bus.tag_error), 64'd1);
`else
        chk("tag_error_tied", 64'(bus.tag_error), 64'd0);
`endif
        check_head("tag_stored", 64'd5);
        chk("tag_stored_tag", 64'(bus.out_tag), 64'h2);
        bus.out_ready = 1'b1;
        tick();
        chk("tag_emitted", 64'(bus.out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/partition_buffer.md
# partition_buffer

Elastic tuple buffer directly downstream of the partitioning gate stage. It accepts the gate's single output stream, which carries data, 32-bit hash tag, 64-bit serial number, was-joined flag and last-processed indication. It stores tuples in a first-word-fall-through FIFO and re-emits them to the partition writer. When the gate reports end-of-stream, the buffer drains, marks the final emitted tuple and raises a sticky done flag.

## Interface
- INPUT_SIZE, 64, tuple payload width in bits
- DEPTH, 16, FIFO entries; power of two, ≥2
- ID, 0, partition this instance serves (bit 0 used)
- DECISION_BIT, 0, tag bit checked against ID[0]

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_ready  out  1  upstream may present a tuple
- in_data  in  INPUT_SIZE  tuple payload
- in_tag  in  32  hash digest
- in_valid  in  1  tuple present
- in_serialnum  in  64  tuple serial number
- in_was_joined  in  1  tuple join flag
- in_last_processed  in  1  upstream has finished (level)
- out_ready  in  1  downstream accepts
- out_data  out  INPUT_SIZE  head payload
- out_tag  out  32  head tag
- out_serialnum  out  64  head serial number
- out_was_joined  out  1  head join flag
- out_valid  out  1  FIFO non-empty
- out_last  out  1  head is the final tuple of the stream
- out_done  out  1  stream fully drained (sticky)
- tuple_count  out  32  tuples accepted since reset
- tag_error  out  1  sticky mis-routed-tuple flag (see Configuration)

## Operation
- FIFO entry holds {data, tag, serialnum, was_joined} = INPUT_SIZE+97 bits. Occupancy counter is $clog2(DEPTH)+1 bits wide.
- Push: in_valid & in_ready. Pop: out_valid & out_ready. Simultaneous push and pop leaves occupancy unchanged.
- in_ready = (state==FILL) & ~full. A pop in the same cycle does not unblock a full FIFO.
- out_valid = ~empty. out_* show the head entry combinationally from storage.
- States:
  - FILL, entered on reset.
  - FILL→DRAIN when in_last_processed=1 & in_valid=0 at a clock edge.
  - DRAIN→DONE when occupancy==0, or on the pop of the entry that leaves occupancy at 0.
  - DONE persists until reset.
- In DRAIN and DONE, in_valid is ignored and in_ready=0.
- out_last = (state==DRAIN) & (occupancy==1). If DRAIN is entered with an empty FIFO, no out_last beat is produced.
- out_done = (state==DONE), registered.
- tuple_count increments on every push and wraps modulo 2^32.
- Read and write pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- Reset values:
  - State FILL, pointers and occupancy 0, tuple_count 0, tag_error 0.
  - Outputs: out_valid 0, out_last 0, out_done 0, in_ready 1.
  - out_data/out_tag/out_serialnum/out_was_joined are 0 (storage cleared).
- Reset asserted mid-stream discards all contents immediately, without waiting for a clock edge.
- Latency: a tuple pushed at edge N is visible with out_valid=1 after edge N (one cycle), provided the FIFO was empty.
- Throughput: one push and one pop per cycle.
- Downstream must hold out_ready as a plain accept. out_* remain stable while out_valid=1 & out_ready=0.
- out_done rises on the edge after the final pop, or one edge after entering DRAIN when already empty.

## Configuration
- PARTITION_BUFFER_TAG_CHECK_EN defined:
  - on every push, if in_tag[DECISION_BIT] != ID[0], tag_error is set at that edge and stays set until reset;
  - the tuple is still stored.
- Macro undefined: tag_error is tied to 0 and no comparison logic is built.

## Test plan
- Reset, push 3 tuples (serial 1,2,3) with out_ready=0 → out_valid=1, head serial 1, tuple_count=3. Then out_ready=1 → serial 1,2,3 on consecutive cycles.
- Push DEPTH=16 tuples with out_ready=0 → in_ready=0 after the 16th. Push+pop in the same cycle while full → push refused, occupancy 15.
- Load 2 tuples, assert in_last_processed=1 with in_valid=0, drain → out_last=1 only with the second tuple. out_done=1 on the following edge and remains 1.
- End-of-stream with an empty FIFO → out_last never asserted, out_done=1 two edges after in_last_processed is sampled.
- Assert reset asynchronously with 5 entries stored → out_valid=0 and tuple_count=0 before the next clk edge. The next push behaves as the first after reset.
- With PARTITION_BUFFER_TAG_CHECK_EN, ID=1, push tag 0x0000_0002 → tag_error=1 and the tuple is still emitted. Without the macro → tag_error=0.
